// File: rtl/wb_ram512_bridge_pkg.sv
// wb_ram512_bridge_pkg: shared widths, clear-sequencer state encodings and response types
// for the Wishbone-to-RAM512 bridge.
package wb_ram512_bridge_pkg;

  localparam int SEL_W = 8;
  localparam int DAT_W = 64;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_CLEAR = 2'd1,
    SEQ_DONE  = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2
  } rsp_t;

  function automatic rsp_t rsp_of(input logic hit);
    return hit ? RSP_ACK : RSP_ERR;
  endfunction

endpackage

// File: rtl/ram512_clear_seq.sv
// ram512_clear_seq: after reset release, writes every RAM address once (0 .. 2**BITS-1),
// one per cycle, then parks in DONE. Only built when RAM_CLEAR_EN is defined.
`ifdef RAM_CLEAR_EN
module ram512_clear_seq
  import wb_ram512_bridge_pkg::*;
#(
  parameter int BITS = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            o_busy,
  output logic            o_en,
  output logic [BITS-1:0] o_addr
);

  localparam logic [BITS-1:0] ADDR_LAST = '1;

  seq_state_t      r_state;
  seq_state_t      w_state_nxt;
  logic [BITS-1:0] r_addr;
  logic [BITS-1:0] w_addr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEQ_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // IDLE already writes address 0, so the whole sweep takes exactly 2**BITS cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    case (r_state)
      SEQ_IDLE: begin
        w_state_nxt = SEQ_CLEAR;
        w_addr_nxt  = r_addr + 1'b1;
      end
      SEQ_CLEAR: begin
        if (r_addr == ADDR_LAST) begin
          w_state_nxt = SEQ_DONE;
        end else begin
          w_addr_nxt = r_addr + 1'b1;
        end
      end
      default: w_state_nxt = SEQ_DONE;
    endcase
  end

  assign o_busy = (r_state != SEQ_DONE);
  // Held off while reset is asserted so the RAM port is quiet during reset.
  assign o_en   = ((r_state == SEQ_IDLE) & rst_n) | (r_state == SEQ_CLEAR);
  assign o_addr = r_addr;

endmodule
`endif

// File: rtl/wb_ram512_bridge.sv
// wb_ram512_bridge: pipelined 64-bit Wishbone slave driving one RAM512 port, fixed 2-cycle latency.
// Define RAM_CLEAR_EN to zero the whole RAM after reset before any request is accepted.
module wb_ram512_bridge
  import wb_ram512_bridge_pkg::*;
#(
  parameter int                  BITS     = 9,
  parameter int                  ADR_BITS = 29,
  parameter logic [ADR_BITS-1:0] BASE     = '0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                wb_cyc,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [SEL_W-1:0]    wb_sel,
  input  logic [ADR_BITS-1:0] wb_adr,
  input  logic [DAT_W-1:0]    wb_dat_w,
  output logic [DAT_W-1:0]    wb_dat_r,
  output logic                wb_ack,
  output logic                wb_err,
  output logic                wb_stall,
  output logic                ram_en,
  output logic [SEL_W-1:0]    ram_we,
  output logic [BITS-1:0]     ram_a,
  output logic [DAT_W-1:0]    ram_di,
  input  logic [DAT_W-1:0]    ram_do
);

  // Handshake: a request transfers on a rising edge where wb_cyc & wb_stb & !wb_stall;
  // its wb_ack/wb_err arrives two cycles later, in order, unless wb_cyc drops first.
  logic w_accept;
  logic w_hit;

  logic                r_s1_vld;
  logic                r_s1_we;
  logic                r_s1_hit;
  logic [SEL_W-1:0]    r_s1_sel;
  logic [BITS-1:0]     r_s1_adr;
  logic [DAT_W-1:0]    r_s1_dat;

  logic                r_s2_vld;
  logic                r_s2_rd;
  rsp_t                r_s2_rsp;

  logic                w_s1_en;
  logic [SEL_W-1:0]    w_s1_we;

  assign w_accept = wb_cyc & wb_stb & ~wb_stall;
  assign w_hit    = (wb_adr[ADR_BITS-1:BITS] == BASE[ADR_BITS-1:BITS]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1_vld <= 1'b0;
      r_s1_we  <= 1'b0;
      r_s1_hit <= 1'b0;
      r_s1_sel <= '0;
      r_s1_adr <= '0;
      r_s1_dat <= '0;
      r_s2_vld <= 1'b0;
      r_s2_rd  <= 1'b0;
      r_s2_rsp <= RSP_NONE;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_we  <= wb_we;
        r_s1_hit <= w_hit;
        r_s1_sel <= wb_sel;
        r_s1_adr <= wb_adr[BITS-1:0];
        r_s1_dat <= wb_dat_w;
      end
      // A cycle with wb_cyc low aborts whatever is in flight.
      r_s2_vld <= r_s1_vld & wb_cyc;
      r_s2_rd  <= ~r_s1_we;
      r_s2_rsp <= rsp_of(r_s1_hit);
    end
  end

  assign w_s1_en = r_s1_vld & r_s1_hit & wb_cyc;
  assign w_s1_we = (w_s1_en & r_s1_we) ? r_s1_sel : '0;

  assign wb_ack   = r_s2_vld & wb_cyc & (r_s2_rsp == RSP_ACK);
  assign wb_err   = r_s2_vld & wb_cyc & (r_s2_rsp == RSP_ERR);
  assign wb_dat_r = (wb_ack & r_s2_rd) ? ram_do : '0;

`ifdef RAM_CLEAR_EN
  logic            w_seq_busy;
  logic            w_seq_en;
  logic [BITS-1:0] w_seq_addr;

  ram512_clear_seq #(
    .BITS (BITS)
  ) u_clear_seq (
    .clk    (CLK),
    .rst_n  (RST_N),
    .o_busy (w_seq_busy),
    .o_en   (w_seq_en),
    .o_addr (w_seq_addr)
  );

  assign wb_stall = w_seq_busy;

  // The clear sweep owns the RAM port until it finishes; stage 1 is empty meanwhile.
  always_comb begin
    ram_en = w_s1_en;
    ram_we = w_s1_we;
    ram_a  = r_s1_adr;
    ram_di = r_s1_dat;
    if (w_seq_busy) begin
      ram_en = w_seq_en;
      ram_we = {SEL_W{w_seq_en}};
      ram_a  = w_seq_addr;
      ram_di = '0;
    end
  end
`else
  assign wb_stall = 1'b0;
  assign ram_en   = w_s1_en;
  assign ram_we   = w_s1_we;
  assign ram_a    = r_s1_adr;
  assign ram_di   = r_s1_dat;
`endif

endmodule

// File: tb/tb_wb_ram512_bridge.sv
// tb_wb_ram512_bridge: directed bench for wb_ram512_bridge paired with a behavioural
// RAM512 (registered, write-first, byte lanes). Also covers RAM_CLEAR_EN when defined.
module tb_wb_ram512_bridge;

  logic        clk = 1'b0;
  logic        RST_N = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [7:0]  wb_sel = '0;
  logic [28:0] wb_adr = '0;
  logic [63:0] wb_dat_w = '0;
  logic [63:0] wb_dat_r;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_stall;
  logic        ram_en;
  logic [7:0]  ram_we;
  logic [8:0]  ram_a;
  logic [63:0] ram_di;
  logic [63:0] ram_do;

  int checks = 0;
  int errors = 0;

`ifdef RAM_CLEAR_EN
  localparam logic EXP_STALL_RST = 1'b1;
`else
  localparam logic EXP_STALL_RST = 1'b0;
`endif

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout no summary reached");
    $fatal(1, "bench timeout");
  end

  wb_ram512_bridge #(
    .BITS     (9),
    .ADR_BITS (29),
    .BASE     (29'h0)
  ) dut (
    .CLK      (clk),
    .RST_N    (RST_N),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_sel   (wb_sel),
    .wb_adr   (wb_adr),
    .wb_dat_w (wb_dat_w),
    .wb_dat_r (wb_dat_r),
    .wb_ack   (wb_ack),
    .wb_err   (wb_err),
    .wb_stall (wb_stall),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_a    (ram_a),
    .ram_di   (ram_di),
    .ram_do   (ram_do)
  );

  // RAM512 model: registered output, write-first, Do=0 when not enabled
  logic [63:0] mem [0:511];
  logic [63:0] ram_merged;

  always_comb begin
    ram_merged = mem[ram_a];
    for (int b = 0; b < 8; b++) begin
      if (ram_we[b]) ram_merged[b*8 +: 8] = ram_di[b*8 +: 8];
    end
  end

  always @(posedge clk) begin
    if (ram_en) begin
      mem[ram_a] <= ram_merged;
      ram_do     <= ram_merged;
    end else begin
      ram_do <= '0;
    end
  end

  // Driver tasks: inputs change just after the falling edge, outputs sampled 1 unit later
  task automatic req(input logic we, input logic [7:0] sel, input logic [28:0] adr,
                     input logic [63:0] dat);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat_w = dat;
    #1;
  endtask

  task automatic idle(input logic cyc);
    @(negedge clk);
    wb_cyc = cyc; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = '0; wb_adr = '0; wb_dat_w = '0;
    #1;
  endtask

  task automatic set_rst(input logic val);
    @(negedge clk);
    RST_N = val; wb_cyc = 1'b0; wb_stb = 1'b0;
    #1;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hA5A5_5A5A_0F0F_F000 | 64'(i);
  endfunction

  initial begin
    int n;
    // Reset state
    idle(1'b0);
    idle(1'b0);
    chk("rst_ack", wb_ack, 1'b0);
    chk("rst_err", wb_err, 1'b0);
    chk("rst_stall", wb_stall, EXP_STALL_RST);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_dat_r", wb_dat_r, 64'h0);
    set_rst(1'b1);

`ifdef RAM_CLEAR_EN
    n = 0;
    while (wb_stall === 1'b1 && n < 600) begin n++; idle(1'b0); end
    chk("clr_stall_cycles", 64'(n), 64'd512);
    n = 0;
    while (ram_a !== 9'd100 && n < 600) begin n++; idle(1'b0); end
    chk("clr_reach_100", ram_en, 1'b1);
    set_rst(1'b0);
    set_rst(1'b1);
    chk("clr_restart_a0", 64'(ram_a), 64'd0);
    n = 0;
    while (wb_stall === 1'b1 && n < 600) begin n++; idle(1'b0); end
    chk("clr_restart_cycles", 64'(n), 64'd512);
    for (int i = 0; i < 514; i++) begin
      if (i < 512) req(1'b0, 8'h00, 29'(i), 64'h0); else idle(1'b1);
      if (i >= 2) begin
        chk("clr_rd_ack", wb_ack, 1'b1);
        chk("clr_rd_dat", wb_dat_r, 64'h0);
      end
    end
`endif

    // 1: write then read adr 5
    req(1'b1, 8'hFF, 29'd5, 64'h0123456789ABCDEF);
    chk("t1_stall", wb_stall, 1'b0);
    chk("t1_ack_early", wb_ack, 1'b0);
    req(1'b0, 8'hFF, 29'd5, 64'h0);
    chk("t1_ram_en", ram_en, 1'b1);
    chk("t1_ram_we", ram_we, 8'hFF);
    chk("t1_ram_a", ram_a, 9'd5);
    chk("t1_ram_di", ram_di, 64'h0123456789ABCDEF);
    chk("t1_wack_early", wb_ack, 1'b0);
    idle(1'b1);
    chk("t1_wack", wb_ack, 1'b1);
    chk("t1_wdat", wb_dat_r, 64'h0);
    chk("t1_rd_we", ram_we, 8'h00);
    idle(1'b1);
    chk("t1_rack", wb_ack, 1'b1);
    chk("t1_rdat", wb_dat_r, 64'h0123456789ABCDEF);
    idle(1'b1);
    chk("t1_idle_ack", wb_ack, 1'b0);

    // sel=0 write is acked and leaves memory unchanged
    req(1'b1, 8'h00, 29'd5, 64'h0);
    req(1'b0, 8'hFF, 29'd5, 64'h0);
    chk("sel0_ram_en", ram_en, 1'b1);
    idle(1'b1);
    chk("sel0_ack", wb_ack, 1'b1);
    idle(1'b1);
    chk("sel0_rdat", wb_dat_r, 64'h0123456789ABCDEF);

    // 2: partial-lane write, read-after-write back to back
    req(1'b1, 8'hFF, 29'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    req(1'b1, 8'h0F, 29'd7, 64'h0);
    req(1'b0, 8'hFF, 29'd7, 64'h0);
    chk("t2_ack_w1", wb_ack, 1'b1);
    idle(1'b1);
    chk("t2_ack_w2", wb_ack, 1'b1);
    idle(1'b1);
    chk("t2_ack_r", wb_ack, 1'b1);
    chk("t2_rdat", wb_dat_r, 64'hFFFF_FFFF_0000_0000);

    // 3: out-of-window read
    req(1'b0, 8'hFF, 29'h200, 64'h0);
    idle(1'b1);
    chk("t3_ram_en_s1", ram_en, 1'b0);
    chk("t3_err_early", wb_err, 1'b0);
    idle(1'b1);
    chk("t3_err", wb_err, 1'b1);
    chk("t3_ack", wb_ack, 1'b0);
    chk("t3_dat", wb_dat_r, 64'h0);
    chk("t3_ram_en_s2", ram_en, 1'b0);

    // 4: streaming writes then 8 consecutive reads
    for (int i = 0; i < 10; i++) begin
      if (i < 8) req(1'b1, 8'hFF, 29'(i), pat(i)); else idle(1'b1);
      chk("t4_wstall", wb_stall, 1'b0);
      if (i >= 2) chk("t4_wack", wb_ack, 1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 8) req(1'b0, 8'hFF, 29'(i), 64'h0); else idle(1'b1);
      chk("t4_rstall", wb_stall, 1'b0);
      if (i >= 2) begin
        chk("t4_rack", wb_ack, 1'b1);
        chk("t4_rdat", wb_dat_r, pat(i - 2));
      end
    end

    // 5: aborted write leaves old data
    req(1'b1, 8'hFF, 29'd3, 64'h1111_2222_3333_4444);
    idle(1'b1);
    idle(1'b1);
    chk("t5_first_ack", wb_ack, 1'b1);
    req(1'b1, 8'hFF, 29'd3, 64'hDEAD_BEEF_DEAD_BEEF);
    idle(1'b0);
    chk("t5_abort_ram_en", ram_en, 1'b0);
    idle(1'b1);
    chk("t5_abort_ack", wb_ack, 1'b0);
    chk("t5_abort_err", wb_err, 1'b0);
    idle(1'b1);
    chk("t5_abort_ack2", wb_ack, 1'b0);
    req(1'b0, 8'hFF, 29'd3, 64'h0);
    idle(1'b1);
    idle(1'b1);
    chk("t5_rack", wb_ack, 1'b1);
    chk("t5_rdat", wb_dat_r, 64'h1111_2222_3333_4444);

    // Reset asserted mid-flight: no response afterwards
    req(1'b0, 8'hFF, 29'd3, 64'h0);
    idle(1'b1);
    @(negedge clk);
    RST_N = 1'b0;
    #1;
    chk("rstmid_ack", wb_ack, 1'b0);
    chk("rstmid_ram_en", ram_en, 1'b0);
    @(negedge clk);
    RST_N = 1'b1;
    #1;
    idle(1'b1);
    chk("rstmid_ack_after", wb_ack, 1'b0);
    chk("rstmid_err_after", wb_err, 1'b0);
    idle(1'b1);
    chk("rstmid_ack_after2", wb_ack, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
